// File: rtl/aes_enc_pipe.sv
// aes_enc_pipe -- fully pipelined AES-128 encryption core.
//
// One 128-bit plaintext block may enter per clock once the round keys are
// expanded. Eleven registered stages (initial AddRoundKey, rounds 1..9,
// final round 10) carry each block together with its own valid bit. A
// sequential key-expansion engine fills round keys k0..k10 from a single
// key load, one round key per cycle, sharing one SubWord (4 S-boxes).
//
// Ports:
//   clk        single clock, rising-edge
//   rst        asynchronous active-low reset
//   KEY        cipher key, sampled when key_load is accepted
//   key_load   one-cycle request to expand KEY
//   key_ready  round keys valid, pipeline accepts data
//   busy       expansion running or any block in flight
//   IN         plaintext block (byte 0 = IN[127:120])
//   in_valid   IN presented this cycle
//   OUT        ciphertext block
//   out_valid  OUT holds a completed ciphertext
//
// Build option:
//   AES_ENC_OUT_GATE_EN  when defined, OUT reads 0 whenever out_valid=0;
//                        otherwise OUT is the raw final-stage register.
module aes_enc_pipe #(
  parameter int BLOCK_LENGTH = 128
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [BLOCK_LENGTH-1:0] KEY,
  input  logic                    key_load,
  output logic                    key_ready,
  output logic                    busy,
  input  logic [BLOCK_LENGTH-1:0] IN,
  input  logic                    in_valid,
  output logic [BLOCK_LENGTH-1:0] OUT,
  output logic                    out_valid
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // State bytes are column-major: byte n = row (n%4), column (n/4),
  // located at bits [127-8n -: 8].
  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    for (int n = 0; n < 16; n++) r[127-8*n -: 8] = SBOX[s[127-8*n -: 8]];
    return r;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++)
        r[127-8*(w+4*c) -: 8] = s[127-8*(w+4*((c+w)%4)) -: 8];
    return r;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    for (int c = 0; c < 4; c++) r[127-32*c -: 32] = mix_column(s[127-32*c -: 32]);
    return r;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

  state_t       state;
  logic [3:0]   rc;
  logic [127:0] rk [0:10];
  logic [127:0] st_p [0:10];
  logic [127:0] rnd [1:10];
  logic [10:0]  vld_p;
  logic         load_accept;
  logic [127:0] prev_key;
  logic [31:0]  rot_word, sub_word, w0, w1, w2, w3;

  // A reload from READY is only taken with nothing in flight, so a block
  // never sees a mix of old and new round keys.
  assign load_accept = key_load & ((state == IDLE) | ((state == READY) & ~(|vld_p)));

  always_comb begin
    prev_key = '0;
    for (int i = 1; i <= 10; i++)
      if (rc == 4'(i)) prev_key = rk[i-1];
  end

  // Single shared SubWord for every expansion step.
  assign rot_word = {prev_key[23:0], prev_key[31:24]};
  assign sub_word = {SBOX[rot_word[31:24]], SBOX[rot_word[23:16]],
                     SBOX[rot_word[15:8]],  SBOX[rot_word[7:0]]};
  assign w0 = prev_key[127:96] ^ sub_word ^ {rcon(rc), 24'h0};
  assign w1 = prev_key[95:64] ^ w0;
  assign w2 = prev_key[63:32] ^ w1;
  assign w3 = prev_key[31:0]  ^ w2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      rc        <= '0;
      key_ready <= 1'b0;
      for (int i = 0; i <= 10; i++) rk[i] <= '0;
    end else begin
      unique case (state)
        IDLE, READY: begin
          if (load_accept) begin
            rk[0]     <= KEY;
            rc        <= 4'd1;
            state     <= EXPAND;
            key_ready <= 1'b0;
          end
        end
        EXPAND: begin
          for (int i = 1; i <= 10; i++)
            if (rc == 4'(i)) rk[i] <= {w0, w1, w2, w3};
          if (rc == 4'd10) begin
            rc        <= '0;
            state     <= READY;
            key_ready <= 1'b1;
          end else begin
            rc <= rc + 4'd1;
          end
        end
        default: begin
          state     <= IDLE;
          key_ready <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    for (int i = 1; i <= 9; i++)
      rnd[i] = mix_columns(shift_rows(sub_bytes(st_p[i-1]))) ^ rk[i];
    rnd[10] = shift_rows(sub_bytes(st_p[9])) ^ rk[10];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i <= 10; i++) st_p[i] <= '0;
      vld_p <= '0;
    end else begin
      // stage 0: initial AddRoundKey
      st_p[0] <= IN ^ rk[0];
      // stages 1..10: full rounds, last one without MixColumns
      for (int i = 1; i <= 10; i++) st_p[i] <= rnd[i];
      // a block offered in the same cycle as an accepted key load is dropped
      vld_p <= {vld_p[9:0], in_valid & key_ready & ~load_accept};
    end
  end

  assign busy      = (state == EXPAND) | (|vld_p);
  assign out_valid = vld_p[10];

`ifdef AES_ENC_OUT_GATE_EN
  assign OUT = vld_p[10] ? st_p[10] : '0;
`else
  assign OUT = st_p[10];
`endif

endmodule
